// File: rtl/sr_pq_pkg.sv
// sr_pq_pkg: shared types for the shift-register priority queue.
//   pq_cell_t  - one storage cell record (valid, key, value). Key and value
//                fields are sized to the widest supported widths. Narrower
//                keys and values are zero-extended, which keeps unsigned
//                ordering intact.
//   cell_op_e  - per-cell update decision.
//   pq_beats() - priority comparison used by every cell.
package sr_pq_pkg;

  localparam int PQ_MIN = 0;
  localparam int PQ_MAX = 1;

  localparam int PQ_KW_MAX = 32;
  localparam int PQ_VW_MAX = 32;

  typedef struct packed {
    logic                 valid;
    logic [PQ_KW_MAX-1:0] key;
    logic [PQ_VW_MAX-1:0] value;
  } pq_cell_t;

  typedef enum logic [2:0] {
    CELL_HOLD,
    CELL_LOAD,
    CELL_PREV,
    CELL_NEXT,
    CELL_CLEAR
  } cell_op_e;

  // True when key a has strictly higher priority than key b. Equal keys do
  // not beat each other, so a new entry lands behind stored equals (FIFO).
  function automatic logic pq_beats(input logic [PQ_KW_MAX-1:0] a,
                                    input logic [PQ_KW_MAX-1:0] b,
                                    input logic                 max_first);
    return max_first ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/sr_pq_cell.sv
// sr_pq_cell: one storage cell of the shift-register priority queue.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   clr_i          - flush: cell becomes invalid
//   push_i, pop_i  - accepted push / accepted pop this cycle
//   new_rec_i      - record being inserted
//   prev_rec_i     - record of the cell nearer the head (zero for cell 0)
//   next_rec_i     - record of the cell nearer the tail (zero past the tail)
//   prev_ins_i     - insert bit of the previous cell (0 for cell 0)
//   next_ins_i     - insert bit of the next cell (1 past the tail)
//   rec_o          - this cell's stored record
//   ins_o          - new key belongs at or before this cell
module sr_pq_cell
  import sr_pq_pkg::*;
#(
  parameter bit MAX_FIRST = 1'b0,
  parameter bit HEAD      = 1'b0
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     clr_i,
  input  logic     push_i,
  input  logic     pop_i,
  input  pq_cell_t new_rec_i,
  input  pq_cell_t prev_rec_i,
  input  pq_cell_t next_rec_i,
  input  logic     prev_ins_i,
  input  logic     next_ins_i,
  output pq_cell_t rec_o,
  output logic     ins_o
);

  pq_cell_t rec_q, rec_d;
  cell_op_e op;

  // Occupied cells are sorted, so ins_o is monotone along the queue: false
  // up to the insert point and true from there on. The first true cell is
  // where the new record goes.
  always_comb begin
    ins_o = !rec_q.valid || pq_beats(new_rec_i.key, rec_q.key, MAX_FIRST);
    op    = CELL_HOLD;
    if (clr_i) begin
      op = CELL_CLEAR;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (prev_ins_i)  op = CELL_PREV;
          else if (ins_o)  op = CELL_LOAD;
          else             op = CELL_HOLD;
        end
        2'b01: op = CELL_NEXT;
        // Push with pop: the queue shifts toward the head and the new record
        // is inserted into the shifted view. A cell whose own insert bit is
        // set already sits behind the insert point and keeps its entry. The
        // head cell's own entry leaves, so the head ignores its own bit.
        2'b11: begin
          if (!HEAD && ins_o) op = CELL_HOLD;
          else if (next_ins_i) op = CELL_LOAD;
          else                 op = CELL_NEXT;
        end
        default: op = CELL_HOLD;
      endcase
    end
  end

  always_comb begin
    rec_d = rec_q;
    case (op)
      CELL_LOAD:  rec_d = new_rec_i;
      CELL_PREV:  rec_d = prev_rec_i;
      CELL_NEXT:  rec_d = next_rec_i;
      CELL_CLEAR: rec_d = '0;
      default:    rec_d = rec_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rec_q <= '0;
    else        rec_q <= rec_d;
  end

  assign rec_o = rec_q;

endmodule

// File: rtl/sr_pq_gen.sv
// sr_pq_gen: shift-register priority queue with single-cycle push/pop.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   clr                    - synchronous flush (all cells invalid, count 0)
//   push_valid/push_kv     - insert offer, {key,value} with key in MSBs
//   push_ready             - insert accepted this cycle
//   pop_valid/pop_ready    - remove-head request / accepted this cycle
//   head_kv, head_valid    - cell 0 contents (zero when invalid)
//   count, full, empty     - occupancy
//   overflow               - sticky: push offered while not ready
module sr_pq_gen
  import sr_pq_pkg::*;
#(
  parameter int KW        = 4,
  parameter int VW        = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_FIRST = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push_valid,
  input  logic [KW+VW-1:0]           push_kv,
  output logic                       push_ready,
  input  logic                       pop_valid,
  output logic                       pop_ready,
  output logic [KW+VW-1:0]           head_kv,
  output logic                       head_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int CW       = $clog2(DEPTH+1);
  localparam bit MAX_MODE = (MAX_FIRST == PQ_MAX);

  pq_cell_t         new_rec;
  pq_cell_t         rec [DEPTH];
  logic [DEPTH-1:0] ins;
  logic             push_acc, pop_acc;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  assign new_rec = {1'b1, PQ_KW_MAX'(push_kv[KW+VW-1:VW]), PQ_VW_MAX'(push_kv[VW-1:0])};

  for (genvar g = 0; g < DEPTH; g++) begin : g_cell
    pq_cell_t prev_rec, next_rec;
    logic     prev_ins, next_ins;

    if (g == 0) begin : g_first
      assign prev_rec = '0;
      assign prev_ins = 1'b0;
    end else begin : g_inner_prev
      assign prev_rec = rec[g-1];
      assign prev_ins = ins[g-1];
    end

    // Past the tail is an empty slot: nothing to shift in, and the new key
    // always fits there.
    if (g == DEPTH-1) begin : g_last
      assign next_rec = '0;
      assign next_ins = 1'b1;
    end else begin : g_inner_next
      assign next_rec = rec[g+1];
      assign next_ins = ins[g+1];
    end

    sr_pq_cell #(
      .MAX_FIRST (MAX_MODE),
      .HEAD      (g == 0)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr_i      (clr),
      .push_i     (push_acc),
      .pop_i      (pop_acc),
      .new_rec_i  (new_rec),
      .prev_rec_i (prev_rec),
      .next_rec_i (next_rec),
      .prev_ins_i (prev_ins),
      .next_ins_i (next_ins),
      .rec_o      (rec[g]),
      .ins_o      (ins[g])
    );
  end

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign pop_ready  = !empty;
  assign push_ready = !full || (pop_valid && !empty);
  assign push_acc   = push_valid && push_ready;
  assign pop_acc    = pop_valid && pop_ready;

  always_comb begin
    if (clr) count_d = '0;
    else     count_d = count_q + CW'(push_acc) - CW'(pop_acc);
    overflow_d = overflow_q | (push_valid & ~push_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign head_valid = rec[0].valid;
  assign head_kv    = head_valid ? {rec[0].key[KW-1:0], rec[0].value[VW-1:0]} : '0;
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_sr_pq_gen.sv
module tb_sr_pq_gen;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clr, push_valid, pop_valid;
  logic [7:0] push_kv;

  logic       pr0, pp0, hv0, full0, empty0, ovf0;
  logic [7:0] hk0;
  logic [3:0] cnt0;
  logic       pr1, pp1, hv1, full1, empty1, ovf1;
  logic [7:0] hk1;
  logic [3:0] cnt1;

  sr_pq_gen #(.KW(4), .VW(4), .DEPTH(8), .MAX_FIRST(0)) dut_min (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push_valid(push_valid), .push_kv(push_kv),
    .push_ready(pr0), .pop_valid(pop_valid), .pop_ready(pp0), .head_kv(hk0),
    .head_valid(hv0), .count(cnt0), .full(full0), .empty(empty0), .overflow(ovf0));

  sr_pq_gen #(.KW(4), .VW(4), .DEPTH(8), .MAX_FIRST(1)) dut_max (
    .clk(clk), .rst_n(rst_n), .clr(clr), .push_valid(push_valid), .push_kv(push_kv),
    .push_ready(pr1), .pop_valid(pop_valid), .pop_ready(pp1), .head_kv(hk1),
    .head_valid(hv1), .count(cnt1), .full(full1), .empty(empty1), .overflow(ovf1));

  int          checks = 0;
  int          errors = 0;
  int          mode   = 0;       // 0 = compare dut_min, 1 = compare dut_max
  logic [7:0]  mq[$];            // reference queue contents, head first
  logic        ovf_m;
  logic [17:0] exp_q[$];         // {push_ready,pop_ready,hv,head_kv,count,full,empty,overflow}
  logic        pr_seen, pp_seen;

  function automatic logic beats(input logic [3:0] a, input logic [3:0] b);
    return (mode == 1) ? (a > b) : (a < b);
  endfunction

  function automatic logic [17:0] obs();
    if (mode == 1) return {pr_seen, pp_seen, hv1, hk1, cnt1, full1, empty1, ovf1};
    return {pr_seen, pp_seen, hv0, hk0, cnt0, full0, empty0, ovf0};
  endfunction

  // Drives one cycle, applies it to the reference queue and queues the
  // expected post-edge observation. Returns #1 after the edge.
  task automatic step(input logic pv, input logic [7:0] kv, input logic popv,
                      input logic cl, input logic rs);
    logic fm, em, pr, pp, found;
    int   pos;
    logic [7:0] hk;
    push_valid = pv; push_kv = kv; pop_valid = popv; clr = cl; rst_n = !rs;
    fm = (mq.size() == 8);
    em = (mq.size() == 0);
    pr = !fm || (popv && !em);
    pp = !em;
    if (rs) begin
      mq.delete();
      ovf_m = 1'b0;
    end else begin
      if (pv && !pr) ovf_m = 1'b1;
      if (cl) mq.delete();
      else begin
        if (popv && pp) void'(mq.pop_front());
        if (pv && pr) begin
          pos = mq.size();
          found = 1'b0;
          for (int i = 0; i < mq.size(); i++)
            if (!found && beats(kv[7:4], mq[i][7:4])) begin pos = i; found = 1'b1; end
          mq.insert(pos, kv);
        end
      end
    end
    hk = (mq.size() != 0) ? mq[0] : 8'h00;
    exp_q.push_back({pr, pp, (mq.size() != 0), hk, 4'(mq.size()),
                     (mq.size() == 8), (mq.size() == 0), ovf_m});
    #1;
    if (mode == 1) begin pr_seen = pr1; pp_seen = pp1; end
    else           begin pr_seen = pr0; pp_seen = pp0; end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [17:0] e, o;
    mode = 0;
    step(1'b1, 8'h11, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_obs got %h want %h", o, e); end
    checks++;
    if ({hv0, hk0, cnt0, full0, empty0, ovf0} !== {1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got %b want %b", {hv0, hk0, cnt0, full0, empty0, ovf0}, 16'b0000000000000010);
    end
  endtask

  task automatic test_order();
    logic [17:0] e, o;
    logic [7:0]  kvs [4] = '{8'h51, 8'h22, 8'h73, 8'h24};
    mode = 0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 4; i++) begin
      step(1'b1, kvs[i], 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL order_push%0d got %h want %h", i, o, e); end
    end
    checks++;
    if ({hk0, cnt0} !== {8'h22, 4'd4}) begin
      errors++; $display("FAIL order_head got %h/%0d want 22/4", hk0, cnt0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL order_pop%0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_overflow();
    logic [17:0] e, o;
    mode = 0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, {4'(k), 4'(k)}, 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL fill%0d got %h want %h", k, o, e); end
    end
    step(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL overflow_obs got %h want %h", o, e); end
    checks++;
    if ({pr_seen, ovf0, hk0, cnt0} !== {1'b0, 1'b1, 8'h11, 4'd8}) begin
      errors++;
      $display("FAIL overflow_flag got rdy=%b ovf=%b head=%h cnt=%0d want rdy=0 ovf=1 head=11 cnt=8",
               pr_seen, ovf0, hk0, cnt0);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e, o;
    mode = 0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int k = 1; k <= 8; k++) begin
      step(1'b1, {4'(k), 4'h0}, 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    step(1'b1, 8'h4F, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL pushpop_full got %h want %h", o, e); end
    checks++;
    if ({hk0, cnt0, ovf0} !== {8'h20, 4'd8, 1'b0}) begin
      errors++; $display("FAIL pushpop_full_state got %h/%0d/%b want 20/8/0", hk0, cnt0, ovf0);
    end
    // drain: expected heads 30,40,4F,50,60,70,80 then empty
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL drain%0d got %h want %h", i, o, e); end
    end
  endtask

  task automatic test_max_mode();
    logic [17:0] e, o;
    logic [7:0]  kvs [3] = '{8'h31, 8'h92, 8'hF3};
    mode = 1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      step(1'b1, kvs[i], 1'b0, 1'b0, 1'b0);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL max_push%0d got %h want %h", i, o, e); end
    end
    checks++;
    if (hk1[7:4] !== 4'hF) begin errors++; $display("FAIL max_head got %h want F", hk1[7:4]); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL max_pop got %h want %h", o, e); end
    checks++;
    if (hk1[7:4] !== 4'h9) begin errors++; $display("FAIL max_head_after_pop got %h want 9", hk1[7:4]); end
    mode = 0;
  endtask

  task automatic test_empty_ops();
    logic [17:0] e, o;
    mode = 0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    step(1'b1, 8'h6A, 1'b1, 1'b0, 1'b0);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL empty_pushpop got %h want %h", o, e); end
    checks++;
    if ({hk0, cnt0} !== {8'h6A, 4'd1}) begin
      errors++; $display("FAIL empty_pushpop_state got %h/%0d want 6a/1", hk0, cnt0);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL empty_pop%0d got %h want %h", i, o, e); end
    end
    checks++;
    if ({pp_seen, cnt0, ovf0, hv0} !== {1'b0, 4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL pop_on_empty got rdy=%b cnt=%0d ovf=%b hv=%b want 0/0/0/0",
                         pp_seen, cnt0, ovf0, hv0);
    end
    step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    void'(exp_q.pop_front());
    step(1'b1, 8'h44, 1'b1, 1'b1, 1'b0);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL clr_priority got %h want %h", o, e); end
  endtask

  task automatic test_reset_mid();
    logic [17:0] e, o;
    mode = 0;
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 8'(k * 17), 1'b0, 1'b0, 1'b0);
      void'(exp_q.pop_front());
    end
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    e = exp_q.pop_front(); o = obs(); checks++;
    if (o !== e) begin errors++; $display("FAIL reset_mid_obs got %h want %h", o, e); end
    checks++;
    if ({cnt0, hv0, ovf0, hk0} !== {4'd0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_mid_state got cnt=%0d hv=%b ovf=%b head=%h want 0/0/0/00",
                         cnt0, hv0, ovf0, hk0);
    end
  endtask

  task automatic test_random(input int m, input int n);
    logic [17:0] e, o;
    logic        pv, popv, cl;
    mode = m;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    void'(exp_q.pop_front());
    for (int i = 0; i < n; i++) begin
      pv   = ($urandom_range(0, 2) != 0);
      popv = (i < n / 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      cl   = ($urandom_range(0, 63) == 0);
      step(pv, 8'($urandom), popv, cl, 1'b0);
      e = exp_q.pop_front(); o = obs(); checks++;
      if (o !== e) begin errors++; $display("FAIL random_m%0d_%0d got %h want %h", m, i, o, e); end
    end
    mode = 0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; push_valid = 1'b0; pop_valid = 1'b0; push_kv = 8'h00;
    ovf_m = 1'b0; pr_seen = 1'b0; pp_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_order();
    test_overflow();
    test_back_to_back();
    test_max_mode();
    test_empty_ops();
    test_reset_mid();
    test_random(0, 300);
    test_random(1, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
